// File: rtl/muldiv_pkg.sv
// Shared types and sizing helpers for the iterative multiply/divide unit.
// Contents:
//   WIDTH_DEF - default operand / HI / LO width
//   CNT_W     - iteration counter width for WIDTH_DEF
//   cntBits() - counter width for an arbitrary WIDTH
//   mdop_t    - E-stage mul/div/move-to operation encodings
//   state_t   - sequencer states
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cntBits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } mdop_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_core.sv
// One iteration of the unsigned multiply / divide datapath (purely combinational).
// Ports:
//   isDiv   in  1        0 = shift-add multiply step, 1 = restoring divide step
//   accIn   in  2*WIDTH  working accumulator
//                        multiply: {partial product, remaining multiplier bits}
//                        divide:   {partial remainder, dividend/quotient bits}
//   operand in  WIDTH    multiplicand (multiply) or divisor (divide)
//   accOut  out 2*WIDTH  accumulator after this iteration
module muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic                 isDiv,
  input  logic [2*WIDTH-1:0]   accIn,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   accOut
);

  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             unusedBits;

  always_comb begin
    // Multiply: add the multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right; the
    // carry out of the add becomes the new MSB.
    mulSum  = {1'b0, accIn[2*WIDTH-1:WIDTH]}
            + (accIn[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    // Divide: bring the next dividend bit into the remainder (guard bit on
    // top) and trial-subtract the divisor; a borrow means "restore".
    shifted = {accIn[2*WIDTH-1:WIDTH], accIn[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, operand};
    if (isDiv) begin
      if (!diff[WIDTH+1]) begin
        accOut = {diff[WIDTH-1:0], accIn[WIDTH-2:0], 1'b1};
      end else begin
        accOut = {shifted[WIDTH-1:0], accIn[WIDTH-2:0], 1'b0};
      end
    end else begin
      accOut = {mulSum, accIn[WIDTH-1:1]};
    end
  end

  // A successful subtract always leaves a remainder below the divisor, so
  // bit WIDTH of the difference is zero whenever it is selected.
  assign unusedBits = diff[WIDTH];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit of the E stage; owns architectural HI/LO.
// Ports:
//   clk     in  1      rising-edge clock
//   reset_n in  1      asynchronous active-low reset
//   startE  in  1      valid mul/div/move-to op in E (already flush-gated)
//   mdopE   in  3      operation, see mdop_t; other codes are ignored
//   srcaE   in  WIDTH  rs: dividend / multiplicand / MTHI-MTLO data
//   srcbE   in  WIDTH  rt: divisor / multiplier
//   hiout   out WIDTH  architectural HI
//   loout   out WIDTH  architectural LO
//   busy    out 1      multi-cycle op in flight
//   done    out 1      one-cycle pulse after a mul/div result lands in HI/LO
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             startE,
  input  logic [2:0]       mdopE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic [WIDTH-1:0] hiout,
  output logic [WIDTH-1:0] loout,
  output logic             busy,
  output logic             done
);

  localparam int             CW   = cntBits(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t               stateReg, stateNext;
  logic [CW-1:0]        cntReg;
  logic [2*WIDTH-1:0]   accReg, accStep;
  logic [WIDTH-1:0]     operandReg, rawAReg;
  logic                 negResReg, negRemReg, divZeroReg;
  logic [WIDTH-1:0]     hiReg, loReg;

  mdop_t                op;
  logic                 accept, isMulOp, isDivOp, isSigned, lastIter;
  logic [WIDTH-1:0]     absA, absB;
  logic [2*WIDTH-1:0]   prodFix;
  logic [WIDTH-1:0]     quot, rem, divLo, divHi;

  assign op       = mdop_t'(mdopE);
  assign isMulOp  = (op == MD_MULT) || (op == MD_MULTU);
  assign isDivOp  = (op == MD_DIV)  || (op == MD_DIVU);
  assign isSigned = (op == MD_MULT) || (op == MD_DIV);
  assign accept   = startE && !busy;
  assign lastIter = busy && (cntReg == LAST);

  // Signed ops iterate on magnitudes; the sign is restored at the end.
  assign absA = (isSigned && srcaE[WIDTH-1]) ? -srcaE : srcaE;
  assign absB = (isSigned && srcbE[WIDTH-1]) ? -srcbE : srcbE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stateReg <= IDLE;
    else          stateReg <= stateNext;
  end

  // FINISH is the done cycle; busy is already low there, so it accepts a
  // new op exactly like IDLE does.
  always_comb begin
    stateNext = stateReg;
    busy      = 1'b0;
    done      = 1'b0;
    case (stateReg)
      IDLE, FINISH: begin
        done      = (stateReg == FINISH);
        stateNext = IDLE;
        if (accept && isMulOp)      stateNext = MUL;
        else if (accept && isDivOp) stateNext = DIV;
      end
      MUL, DIV: begin
        busy = 1'b1;
        if (cntReg == LAST) stateNext = FINISH;
      end
      default: stateNext = IDLE;
    endcase
  end

  muldiv_core #(.WIDTH(WIDTH)) uCore (
    .isDiv   (stateReg == DIV),
    .accIn   (accReg),
    .operand (operandReg),
    .accOut  (accStep)
  );

  // Working registers: loaded on acceptance, stepped once per busy cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cntReg     <= '0;
      accReg     <= '0;
      operandReg <= '0;
      rawAReg    <= '0;
      negResReg  <= 1'b0;
      negRemReg  <= 1'b0;
      divZeroReg <= 1'b0;
    end else if (accept && (isMulOp || isDivOp)) begin
      cntReg     <= '0;
      accReg     <= {{WIDTH{1'b0}}, (isMulOp ? absB : absA)};
      operandReg <= isMulOp ? absA : absB;
      rawAReg    <= srcaE;
      negResReg  <= isSigned && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
      negRemReg  <= isSigned && srcaE[WIDTH-1];
      divZeroReg <= isDivOp && (srcbE == '0);
    end else if (busy) begin
      cntReg <= cntReg + CW'(1);
      accReg <= accStep;
    end
  end

  // Result formation from the final iteration, with sign fix-up.
  assign prodFix = negResReg ? -accStep : accStep;
  assign quot    = accStep[WIDTH-1:0];
  assign rem     = accStep[2*WIDTH-1:WIDTH];
  // Divide by zero is forced rather than taken from the iteration so the
  // result does not depend on how the datapath behaves with a zero divisor.
  assign divLo   = divZeroReg ? {WIDTH{1'b1}} : (negResReg ? -quot : quot);
  assign divHi   = divZeroReg ? rawAReg       : (negRemReg ? -rem  : rem);

  // HI/LO change only on a move-to or on the last iteration edge, so
  // partial results are never visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hiReg <= '0;
      loReg <= '0;
    end else if (accept && (op == MD_MTHI)) begin
      hiReg <= srcaE;
    end else if (accept && (op == MD_MTLO)) begin
      loReg <= srcaE;
    end else if (lastIter) begin
      if (stateReg == MUL) begin
        hiReg <= prodFix[2*WIDTH-1:WIDTH];
        loReg <= prodFix[WIDTH-1:0];
      end else begin
        hiReg <= divHi;
        loReg <= divLo;
      end
    end
  end

  assign hiout = hiReg;
  assign loout = loReg;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the Execute stage of the pipelined MIPS core. It holds the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exports busy to the hazard unit, which stalls F/D while an op is in flight and a MFHI/MFLO/mul-div instruction waits in D.
- MFHI/MFLO read hiout/loout combinationally in E.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
startE  in  1  valid mul/div/mt op in E; already gated by flushE
mdopE  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved
srcaE  in  WIDTH  rs operand (dividend / multiplicand / MT data)
srcbE  in  WIDTH  rt operand (divisor / multiplier)
hiout  out  WIDTH  architectural HI
loout  out  WIDTH  architectural LO
busy  out  1  multi-cycle op in progress
done  out  1  one-cycle pulse after HI/LO update from mul/div

Behaviour:
- Reset (asynchronous, any cycle including mid-op):
  - hiout=0, loout=0, busy=0, done=0, FSM=IDLE.
  - Counter and working registers are cleared; the in-flight op is discarded.
- FSM states:
  - IDLE -> MUL on accepted MULT/MULTU.
  - IDLE -> DIV on accepted DIV/DIVU.
  - MUL/DIV -> FINISH when counter reaches WIDTH-1.
  - FINISH -> IDLE unconditionally.
- Acceptance: an op is accepted at edge E0 iff startE=1 and busy=0.
  - startE while busy=1 is ignored; HI/LO and the in-flight op are unaffected. The hazard contract forbids it.
  - Reserved mdopE: ignored, no state change.
- MTHI/MTLO:
  - Single cycle: hiout (or loout) = srcaE after E0.
  - busy stays 0; no done pulse.
- Operand capture at E0:
  - Signed ops store |srcaE| and |srcbE| plus sign flags.
  - Unsigned ops store raw values.
  - The counter clears.
- Multiply: radix-2 shift-add, one iteration per cycle, 2*WIDTH-bit accumulator.
- Divide: restoring, one quotient bit per cycle, WIDTH-bit partial remainder with one guard bit.
- Latency:
  - busy=1 from E0 through edge E(WIDTH); WIDTH iteration edges E1..E(WIDTH).
  - At E(WIDTH): sign fix-up is applied, HI/LO are loaded, busy falls, done=1 for exactly one cycle.
  - With WIDTH=32: HI/LO are valid 32 cycles after the start edge.
- HI/LO hold their old values throughout busy; intermediate values are never visible.
- Sign rules:
  - Signed product is negated iff operand signs differ.
  - Signed quotient is negated iff signs differ.
  - Remainder takes the dividend's sign.
- Multiply result: HI = product[2W-1:W], LO = product[W-1:0].
- Divide result: LO = quotient, HI = remainder.
- Divide by zero (both DIV/DIVU): LO = all ones, HI = srcaE as captured. Explicit override, not iteration-dependent.
- Signed overflow: 0x80000000 / -1 gives LO=0x80000000, HI=0.
- A new startE in the same cycle as done is accepted (busy already 0).

Decomposition:
- Package muldiv_pkg:
  - mdop_t enum (6 encodings above).
  - state_t enum (IDLE, MUL, DIV, FINISH).
  - Localparam for counter width, $clog2(WIDTH).
- Sub-module muldiv_core:
  - Per-cycle shift-add / shift-subtract datapath.
  - Combinational step from {acc, operands, mode} to next {acc}.
- muldiv_unit owns:
  - FSM.
  - Counter.
  - HI/LO registers.
  - Sign capture/fix-up.
  - Divide-by-zero override.

Test Plan:
- Reset asserted mid-idle and mid-DIV (cycle 10 of 32) -> hiout=0, loout=0, busy=0, done=0 immediately, without waiting for a clock edge.
- MULTU srca=0xFFFFFFFF srcb=2 -> busy high 32 cycles, HI/LO unchanged during, then HI=0x00000001, LO=0xFFFFFFFE, done one cycle.
- MULT srca=-3 (0xFFFFFFFD) srcb=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Signed and zero divides:
  - DIV -7 by 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000 by -1 -> LO=0x80000000, HI=0.
  - DIVU 7 by 0 -> LO=0xFFFFFFFF, HI=0x00000007.
- MTHI srca=0x1234 while idle -> hiout=0x1234 next cycle, busy stays 0.
- MULTU 3*4 followed by MULTU 5*6 on startE at cycle 5 of busy -> second ignored, final LO=12, HI=0.
- Back-to-back MULTU 2*3 then MTLO 9 issued in the done cycle -> LO=6 at done, then LO=9 the next cycle.
